// File: rtl/ingress_queue.sv
// ingress_queue
//   Per-port ingress buffer feeding the per-egress round-robin scheduler.
//   Upstream words (valid/ready/last) are stored in a first-word-fall-through
//   data FIFO. The destination index of every frame is lifted from its first
//   word into a small parallel destination FIFO. The head word, its last flag
//   and the head frame's destination are presented to the scheduler/crossbar.
//
// Build option:
//   INGRESS_STORE_FORWARD_EN  defined   -> a frame is offered only once its last
//                                          word is stored (or the data FIFO is
//                                          full, as a deadlock escape).
//                             undefined -> cut-through, offered as soon as stored.
//
// Ports:
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   s_data/s_valid/s_last/s_ready
//                      upstream stream; s_ready depends on registered state only
//   ingress_data/ingress_valid/ingress_last/ingress_dst
//                      head word and head-frame destination; zero while !ingress_valid
//   ingress_ready      head word consumed when ingress_valid is also high
//   level              words stored (0..DEPTH)
//   frames             complete frames stored (last word written, not yet popped)
//
// DEPTH and FRAME_DEPTH must be powers of two, each at least 2.

module ingress_queue #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int FRAME_DEPTH = 8,
  parameter int IDX_WIDTH   = 2,
  parameter int DST_LSB     = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [DATA_WIDTH-1:0]          s_data,
  input  logic                           s_valid,
  input  logic                           s_last,
  output logic                           s_ready,
  output logic [DATA_WIDTH-1:0]          ingress_data,
  output logic                           ingress_valid,
  output logic                           ingress_last,
  output logic [IDX_WIDTH-1:0]           ingress_dst,
  input  logic                           ingress_ready,
  output logic [$clog2(DEPTH):0]         level,
  output logic [$clog2(FRAME_DEPTH):0]   frames
);

  localparam int AW  = $clog2(DEPTH);
  localparam int FAW = $clog2(FRAME_DEPTH);

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  // storage (no reset)
  word_t                mem  [DEPTH];
  logic [IDX_WIDTH-1:0] dmem [FRAME_DEPTH];

  // pointers carry one extra wrap bit
  logic [AW:0]  wr_ptr, rd_ptr;
  logic [FAW:0] dwr_ptr, drd_ptr;
  logic [FAW:0] frame_cnt;
  logic         sof;
  logic         run;   // low in reset, rises on the first edge after release

  logic  empty, data_full, dst_full;
  logic  push, pop, pop_last, head_vld;
  word_t head;

  assign empty     = (wr_ptr == rd_ptr);
  assign data_full = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign dst_full  = (dwr_ptr[FAW-1:0] == drd_ptr[FAW-1:0]) && (dwr_ptr[FAW] != drd_ptr[FAW]);

  // A frame start also needs a destination slot; continuation words do not.
  assign s_ready = run && !data_full && !(sof && dst_full);
  assign push    = s_valid && s_ready;

  assign head = mem[rd_ptr[AW-1:0]];

`ifdef INGRESS_STORE_FORWARD_EN
  // The head frame is the oldest, so any complete frame means the head one is
  // complete. A full FIFO holding a single over-long frame falls back to
  // cut-through so it can drain.
  assign head_vld = !empty && ((frame_cnt != '0) || data_full);
`else
  assign head_vld = !empty;
`endif

  assign pop      = head_vld && ingress_ready;
  assign pop_last = pop && head.last;

  // Outputs are forced to zero while nothing is offered so the unreset
  // storage never leaks X/stale data (notably during reset).
  assign ingress_valid = head_vld;
  assign ingress_data  = head_vld ? head.data : '0;
  assign ingress_last  = head_vld && head.last;
  assign ingress_dst   = head_vld ? dmem[drd_ptr[FAW-1:0]] : '0;

  assign level  = wr_ptr - rd_ptr;
  assign frames = frame_cnt;

  // storage writes
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= '{last: s_last, data: s_data};
      if (sof) dmem[dwr_ptr[FAW-1:0]] <= s_data[DST_LSB +: IDX_WIDTH];
    end
  end

  // control state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      dwr_ptr   <= '0;
      drd_ptr   <= '0;
      frame_cnt <= '0;
      sof       <= 1'b1;
      run       <= 1'b0;
    end else begin
      run <= 1'b1;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        sof    <= s_last;
        if (sof) dwr_ptr <= dwr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (pop_last) drd_ptr <= drd_ptr + 1'b1;
      case ({push && s_last, pop_last})
        2'b10:   frame_cnt <= frame_cnt + 1'b1;
        2'b01:   frame_cnt <= frame_cnt - 1'b1;
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

endmodule
